comp4b_result_collector: RTL and testbench

- Downstream stage of the 4-bit comparator.
- Consumes each operand pair (a, b) together with the comparator's g/e/l flags through a valid/ready handshake.
- Accumulates BURST comparisons into a summary: running maximum plus greater/equal/less counts.
- Presents the summary on a valid/ready output port, where a checker or scoreboard consumes it.

---
 rtl/comp4b_result_collector_if.sv | 30 +++
 rtl/comp4b_result_collector.sv | 96 +++++++++
 tb/tb_comp4b_result_collector.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/comp4b_result_collector_if.sv
// Handshake bundle between the 4-bit comparator, the result collector and the summary consumer.
// The err signal exists only when COMP4B_ONEHOT_CHECK_EN is defined.
interface comp4b_result_collector_if #(parameter int CW = 4);
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    a;
  logic [3:0]    b;
  logic          g;
  logic          e;
  logic          l;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    max_val;
  logic [CW-1:0] g_cnt;
  logic [CW-1:0] e_cnt;
  logic [CW-1:0] l_cnt;
`ifdef COMP4B_ONEHOT_CHECK_EN
  logic          err;

  modport master (output in_valid, a, b, g, e, l, out_ready,
                  input  in_ready, out_valid, max_val, g_cnt, e_cnt, l_cnt, err);
  modport slave  (input  in_valid, a, b, g, e, l, out_ready,
                  output in_ready, out_valid, max_val, g_cnt, e_cnt, l_cnt, err);
`else
  modport master (output in_valid, a, b, g, e, l, out_ready,
                  input  in_ready, out_valid, max_val, g_cnt, e_cnt, l_cnt);
  modport slave  (input  in_valid, a, b, g, e, l, out_ready,
                  output in_ready, out_valid, max_val, g_cnt, e_cnt, l_cnt);
`endif
endinterface

// File: rtl/comp4b_result_collector.sv
// Collects BURST comparator results into a max/g/e/l summary and reports it over valid/ready.
// Optional macro COMP4B_ONEHOT_CHECK_EN drops non-one-hot flag beats and raises sticky err.
module comp4b_result_collector #(
  parameter int BURST = 8,
  parameter int CW    = 4
) (
  input  logic clk,
  input  logic rst,
  comp4b_result_collector_if.slave bus
);
  typedef enum logic {ACCUM, REPORT} state_e;

  localparam logic [CW-1:0] LAST = CW'(BURST - 1);

  state_e        state_q;
  logic [CW-1:0] bcnt_q, g_q, e_q, l_q;
  logic [3:0]    max_q;
  logic          ov_q, ir_q;
  logic          acc, clean;
  logic [3:0]    pmax;

  assign acc  = bus.in_valid & ir_q;
  assign pmax = bus.g ? bus.a : bus.b;

`ifdef COMP4B_ONEHOT_CHECK_EN
  logic err_q;
  assign clean   = ({bus.g, bus.e, bus.l} == 3'b100) ||
                   ({bus.g, bus.e, bus.l} == 3'b010) ||
                   ({bus.g, bus.e, bus.l} == 3'b001);
  assign bus.err = err_q;
`else
  // e is implied by "neither g nor l", so the flag itself is never consulted.
  logic unused_e;
  assign clean    = 1'b1;
  assign unused_e = bus.e;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      bcnt_q  <= '0;
      g_q     <= '0;
      e_q     <= '0;
      l_q     <= '0;
      max_q   <= '0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b1;
`ifdef COMP4B_ONEHOT_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        ACCUM: begin
          if (acc && clean) begin
            if (bus.g)      g_q <= g_q + 1'b1;
            else if (bus.l) l_q <= l_q + 1'b1;
            else            e_q <= e_q + 1'b1;
            // First beat reloads, so a previous burst's max never leaks in.
            if (bcnt_q == '0 || pmax > max_q) max_q <= pmax;
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == LAST) begin
              state_q <= REPORT;
              ov_q    <= 1'b1;
              ir_q    <= 1'b0;
            end
          end
`ifdef COMP4B_ONEHOT_CHECK_EN
          if (acc && !clean) err_q <= 1'b1;
`endif
        end
        REPORT: begin
          if (bus.out_ready) begin
            state_q <= ACCUM;
            ov_q    <= 1'b0;
            ir_q    <= 1'b1;
            bcnt_q  <= '0;
            g_q     <= '0;
            e_q     <= '0;
            l_q     <= '0;
`ifdef COMP4B_ONEHOT_CHECK_EN
            err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = ir_q;
  assign bus.out_valid = ov_q;
  assign bus.max_val   = max_q;
  assign bus.g_cnt     = g_q;
  assign bus.e_cnt     = e_q;
  assign bus.l_cnt     = l_q;
endmodule

// File: tb/tb_comp4b_result_collector.sv
// Directed bench for comp4b_result_collector: queue-based summary model checked every cycle,
// plus literal expectations from hand-worked bursts.
module tb_comp4b_result_collector;
  localparam int BURST = 8;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  comp4b_result_collector_if #(.CW(CW)) bus();

  comp4b_result_collector #(.BURST(BURST), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Model: beats of the current burst held in a queue; summary derived from it on demand.
  typedef struct {
    logic [3:0] a, b;
    logic       g, e, l;
  } beat_t;

  beat_t      q[$];
  bit         m_rep  = 1'b0;
  logic [3:0] m_hold = 4'd0;
  bit         m_err  = 1'b0;

  function automatic void summ(output int mx, output int gc, output int ec, output int lc);
    mx = 0; gc = 0; ec = 0; lc = 0;
    foreach (q[i]) begin
      int pm;
      pm = q[i].g ? int'(q[i].a) : int'(q[i].b);
      if (pm > mx) mx = pm;
      if (q[i].g)      gc++;
      else if (q[i].l) lc++;
      else             ec++;
    end
    if (q.size() == 0) mx = int'(m_hold);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_rep  = 1'b0;
      m_hold = 4'd0;
      m_err  = 1'b0;
    end else if (m_rep) begin
      if (bus.out_ready) begin
        int mx, gc, ec, lc;
        summ(mx, gc, ec, lc);
        m_hold = 4'(mx);
        q.delete();
        m_rep = 1'b0;
        m_err = 1'b0;
      end
    end else if (bus.in_valid) begin
      beat_t bt;
      bt.a = bus.a; bt.b = bus.b; bt.g = bus.g; bt.e = bus.e; bt.l = bus.l;
`ifdef COMP4B_ONEHOT_CHECK_EN
      if ((int'(bt.g) + int'(bt.e) + int'(bt.l)) != 1) m_err = 1'b1;
      else q.push_back(bt);
`else
      q.push_back(bt);
`endif
      if (q.size() == BURST) m_rep = 1'b1;
    end
  end

  always @(negedge clk) begin
    int mx, gc, ec, lc;
    summ(mx, gc, ec, lc);
    chk("in_ready",  bus.in_ready,  !m_rep);
    chk("out_valid", bus.out_valid, m_rep);
    chk("max_val",   bus.max_val,   mx);
    chk("g_cnt",     bus.g_cnt,     gc);
    chk("e_cnt",     bus.e_cnt,     ec);
    chk("l_cnt",     bus.l_cnt,     lc);
`ifdef COMP4B_ONEHOT_CHECK_EN
    chk("err",       bus.err,       m_err);
`endif
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b,
                      input logic g, input logic e, input logic l);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = a; bus.b = b; bus.g = g; bus.e = e; bus.l = l;
      ok = bus.in_ready;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'd1);
  endtask

  task automatic sendc(input logic [3:0] a, input logic [3:0] b);
    send(a, b, a > b, a == b, a < b);
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a = 'x;
    bus.b = 4'($urandom);
    {bus.g, bus.e, bus.l} = 3'($urandom);
  endtask

  logic [3:0] va [8] = '{4'd3, 4'd2, 4'd0, 4'd9, 4'd7, 4'd1,  4'd6, 4'd4};
  logic [3:0] vb [8] = '{4'd1, 4'd2, 4'd5, 4'd4, 4'd7, 4'd15, 4'd2, 4'd4};

  task automatic burst1();
    for (int i = 0; i < 8; i++) sendc(va[i], vb[i]);
  endtask

  task automatic pin_summary(input string nm, input int mx, input int gc, input int ec, input int lc);
    chk({nm, "_ov"}, bus.out_valid, 1);
    chk({nm, "_max"}, bus.max_val, mx);
    chk({nm, "_g"}, bus.g_cnt, gc);
    chk({nm, "_e"}, bus.e_cnt, ec);
    chk({nm, "_l"}, bus.l_cnt, lc);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.a = '0; bus.b = '0; bus.g = 1'b0; bus.e = 1'b0; bus.l = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_max", bus.max_val, 0);
    rst = 1'b0;

    // Basic burst, summary one cycle after beat 8, in_ready back after handshake.
    burst1();
    idle();
    pin_summary("t1", 15, 3, 3, 2);
    idle();
    chk("t1_ready_back", bus.in_ready, 1);
    chk("t1_gcnt_clr", bus.g_cnt, 0);

    // Backpressure with extra offered beats while reporting.
    bus.out_ready = 1'b0;
    burst1();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1; bus.a = 4'd15; bus.b = 4'd15; {bus.g, bus.e, bus.l} = 3'b100;
      pin_summary("t2_hold", 15, 3, 3, 2);
      chk("t2_ready_lo", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    idle();
    chk("t2_ready_back", bus.in_ready, 1);
    chk("t2_e_clr", bus.e_cnt, 0);
    chk("t2_max_held", bus.max_val, 15);

    // Back-to-back bursts; second max must not inherit 15.
    burst1();
    for (int i = 0; i < 8; i++) sendc(4'd0, 4'd1);
    idle();
    pin_summary("t3", 1, 0, 0, 8);

    // Async reset mid-burst, then 8 fresh beats required.
    idle();
    for (int i = 0; i < 5; i++) sendc(va[i], vb[i]);
    idle();
    #2 rst = 1'b1;
    #1;
    chk("t4_rst_g", bus.g_cnt, 0);
    chk("t4_rst_e", bus.e_cnt, 0);
    chk("t4_rst_max", bus.max_val, 0);
    chk("t4_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 7; i++) sendc(va[i], vb[i]);
    idle();
    chk("t4_no_early", bus.out_valid, 0);
    sendc(va[7], vb[7]);
    idle();
    pin_summary("t4", 15, 3, 3, 2);

    // Sparse valid with garbage between beats gives the same summary.
    idle();
    for (int i = 0; i < 8; i++) begin
      sendc(va[i], vb[i]);
      idle();
    end
    pin_summary("t5", 15, 3, 3, 2);

`ifdef COMP4B_ONEHOT_CHECK_EN
    // Beat 3 has g and l set: dropped, err sticky until handshake.
    idle();
    sendc(va[0], vb[0]);
    sendc(va[1], vb[1]);
    send(4'd0, 4'd5, 1'b1, 1'b0, 1'b1);
    idle();
    chk("t6_err_set", bus.err, 1);
    chk("t6_drop_g", bus.g_cnt, 1);
    for (int i = 2; i < 8; i++) sendc(va[i], vb[i]);
    idle();
    pin_summary("t6", 15, 3, 3, 2);
    chk("t6_err_hold", bus.err, 1);
    idle();
    chk("t6_err_clr", bus.err, 0);
`else
    // Priority decode: g beats g over l, all-low counts as e.
    idle();
    send(4'd2, 4'd9, 1'b1, 1'b0, 1'b1);
    send(4'd5, 4'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 8; i++) sendc(va[i], vb[i]);
    idle();
    pin_summary("t6", 15, 3, 3, 2);
`endif

    idle();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
